// File: rtl/lms_weight_update.sv
// -----------------------------------------------------------------------------
// lms_weight_update
//
// Pipelined weight-update engine for the adaptive filter. Holds TAPS signed
// weights and applies W[k] <= sat(W[k] +/- X +/- A) to one tap per accepted
// beat. A clear sequencer zeroes the weights one per cycle after reset or on a
// clear pulse. Beats walk the taps in order; frame_start restarts at tap 0.
//
// Pipeline (accept at edge E0):
//   E0   input register captures tap, X, A and the subtract flags
//   E0+1 stage 1 captures the old weight (forwarded if being written) and
//        the conditionally inverted operands plus carry-ins
//   E0+2 stage 2 sums in WIDTH+2 bits, clamps, writes W[tap], strobes out
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               one-cycle pulse, zeroes all weights
//   in_valid/in_ready   update beat handshake
//   frame_start         beat goes to tap 0
//   x_in, a_in          signed operands
//   sub_x, sub_a        1 = subtract the operand, 0 = add it
//   out_valid           one-cycle strobe per written weight
//   out_tap, out_w      tap written and its new value
//   out_sat             the clamp changed the value
//   rd_addr, rd_data    registered filter read port, write-first
// -----------------------------------------------------------------------------
module lms_weight_update #(
  parameter  int WIDTH = 10,
  parameter  int TAPS  = 8,
  localparam int TW    = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             frame_start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic             sub_x,
  input  logic             sub_a,
  output logic             out_valid,
  output logic [TW-1:0]    out_tap,
  output logic [WIDTH-1:0] out_w,
  output logic             out_sat,
  input  logic [TW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int                      DEPTH    = 1 << TW;
  localparam logic [TW-1:0]           LAST_TAP = TW'(TAPS - 1);
  localparam logic signed [WIDTH+1:0] SAT_MAX  = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH+1:0] SAT_MIN  = {3'b111, {(WIDTH-1){1'b0}}};

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    clr_idx_q, clr_idx_d;
  logic [TW-1:0]    tap_idx_q, tap_idx_d;
  logic [TW-1:0]    tap_use;
  logic             accept;

  // Input register
  logic             s0_valid;
  logic [TW-1:0]    s0_tap;
  logic [WIDTH-1:0] s0_x, s0_a;
  logic             s0_sub_x, s0_sub_a;

  // Stage 1
  logic             s1_valid;
  logic [TW-1:0]    s1_tap;
  logic [WIDTH-1:0] s1_w, s1_x, s1_a;
  logic [1:0]       s1_cin;

  // Stage 2 (combinational result, registered into the outputs)
  logic signed [WIDTH+1:0] sum;
  logic [WIDTH-1:0]        res_w;
  logic                    res_sat;
  logic                    s2_fire;
  logic [WIDTH-1:0]        old_w;

  // Weight storage write port
  logic             wr_en;
  logic [TW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] w_mem [DEPTH];

  assign in_ready = (state_q == ST_RUN) && !clear;
  assign accept   = in_valid && in_ready;
  assign tap_use  = frame_start ? '0 : tap_idx_q;
  // A clear pulse kills everything in flight, whatever the state.
  assign s2_fire  = s1_valid && !clear;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      tap_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      tap_idx_q <= tap_idx_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value held and infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    tap_idx_d = tap_idx_q;
    unique case (state_q)
      ST_CLEAR: begin
        if (clear) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == LAST_TAP) begin
          state_d   = ST_RUN;
          clr_idx_d = '0;
          tap_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + TW'(1);
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end else if (accept) begin
          tap_idx_d = (tap_use == LAST_TAP) ? '0 : tap_use + TW'(1);
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 2 arithmetic: the two's-complement +1 of each subtracted operand
  // arrives as a carry-in rather than a separate negation.
  // ---------------------------------------------------------------------------
  always_comb begin
    sum = $signed({{2{s1_w[WIDTH-1]}}, s1_w})
        + $signed({{2{s1_x[WIDTH-1]}}, s1_x})
        + $signed({{2{s1_a[WIDTH-1]}}, s1_a})
        + $signed({{WIDTH{1'b0}}, s1_cin});
    res_w   = sum[WIDTH-1:0];
    res_sat = 1'b0;
    if (sum > SAT_MAX) begin
      res_w   = SAT_MAX[WIDTH-1:0];
      res_sat = 1'b1;
    end else if (sum < SAT_MIN) begin
      res_w   = SAT_MIN[WIDTH-1:0];
      res_sat = 1'b1;
    end
  end

  // Back-to-back beats on the same tap: the weight being written this edge is
  // not yet in storage, so take it straight from stage 2.
  assign old_w = (s2_fire && (s1_tap == s0_tap)) ? res_w : w_mem[s0_tap];

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid  <= 1'b0;
      s0_tap    <= '0;
      s0_x      <= '0;
      s0_a      <= '0;
      s0_sub_x  <= 1'b0;
      s0_sub_a  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_tap    <= '0;
      s1_w      <= '0;
      s1_x      <= '0;
      s1_a      <= '0;
      s1_cin    <= '0;
      out_valid <= 1'b0;
      out_tap   <= '0;
      out_w     <= '0;
      out_sat   <= 1'b0;
    end else begin
      s0_valid  <= accept;
      s0_tap    <= tap_use;
      s0_x      <= x_in;
      s0_a      <= a_in;
      s0_sub_x  <= sub_x;
      s0_sub_a  <= sub_a;
      s1_valid  <= s0_valid && !clear;
      s1_tap    <= s0_tap;
      s1_w      <= old_w;
      s1_x      <= s0_x ^ {WIDTH{s0_sub_x}};
      s1_a      <= s0_a ^ {WIDTH{s0_sub_a}};
      s1_cin    <= {1'b0, s0_sub_x} + {1'b0, s0_sub_a};
      out_valid <= s2_fire;
      if (s2_fire) begin
        out_tap <= s1_tap;
        out_w   <= res_w;
        out_sat <= res_sat;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Weight storage: one write per cycle, either the clear sweep or stage 2.
  // Clear entry flushes the pipeline, so the two never collide.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = s1_tap;
    wr_data = res_w;
    if (state_q == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_idx_q;
      wr_data = '0;
    end else if (s2_fire) begin
      wr_en = 1'b1;
    end
  end

  // NOTE: the weight array has no reset; the clear sweep that follows every
  // reset zeroes it, which keeps it mappable to plain storage.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      w_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      rd_data <= wr_data;
    end else begin
      rd_data <= w_mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_lms_weight_update.sv
// -----------------------------------------------------------------------------
// tb_lms_weight_update
//
// Directed bench for lms_weight_update. One instance with WIDTH=10, TAPS=8 and
// one with TAPS=1 share clock and reset. Expected values are hand-computed.
// Inputs change 1 ns after a rising edge; outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_lms_weight_update;

  localparam int WIDTH = 10;
  localparam int TAPS  = 8;
  localparam int TW    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance (TAPS = 8)
  logic             clear = 1'b0, in_valid = 1'b0, frame_start = 1'b0;
  logic             sub_x = 1'b0, sub_a = 1'b0;
  logic [WIDTH-1:0] x_in = '0, a_in = '0;
  logic [TW-1:0]    rd_addr = '0;
  logic             in_ready, out_valid, out_sat;
  logic [TW-1:0]    out_tap;
  logic [WIDTH-1:0] out_w, rd_data;

  // Single-tap instance
  logic             t1_clear = 1'b0, t1_in_valid = 1'b0, t1_frame_start = 1'b0;
  logic             t1_sub_x = 1'b0, t1_sub_a = 1'b0;
  logic [WIDTH-1:0] t1_x_in = '0, t1_a_in = '0;
  logic [0:0]       t1_rd_addr = '0;
  logic             t1_in_ready, t1_out_valid, t1_out_sat;
  logic [0:0]       t1_out_tap;
  logic [WIDTH-1:0] t1_out_w, t1_rd_data;

  int checks = 0;
  int errors = 0;

  int exp_b1_w[4]    = '{8, -2, 2, -8};
  int exp_b2_tap[5]  = '{0, 1, 0, 1, 2};
  int exp_b2_w[5]    = '{10, 0, 12, 2, 511};
  int exp_b2_sat[5]  = '{0, 0, 0, 0, 1};

  lms_weight_update #(.WIDTH(WIDTH), .TAPS(TAPS)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .frame_start(frame_start),
    .x_in(x_in), .a_in(a_in), .sub_x(sub_x), .sub_a(sub_a),
    .out_valid(out_valid), .out_tap(out_tap), .out_w(out_w), .out_sat(out_sat),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  lms_weight_update #(.WIDTH(WIDTH), .TAPS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(t1_clear),
    .in_valid(t1_in_valid), .in_ready(t1_in_ready), .frame_start(t1_frame_start),
    .x_in(t1_x_in), .a_in(t1_a_in), .sub_x(t1_sub_x), .sub_a(t1_sub_a),
    .out_valid(t1_out_valid), .out_tap(t1_out_tap), .out_w(t1_out_w), .out_sat(t1_out_sat),
    .rd_addr(t1_rd_addr), .rd_data(t1_rd_data)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic fs, input int x, input int a,
                       input logic sx, input logic sa);
    in_valid    = v;
    frame_start = fs;
    x_in        = WIDTH'(x);
    a_in        = WIDTH'(a);
    sub_x       = sx;
    sub_a       = sa;
  endtask

  // One isolated beat: checks latency 2, the written value and a single strobe.
  task automatic single(input logic fs, input int x, input int a, input logic sx,
                        input logic sa, input int etap, input int ew, input logic esat);
    drive(1'b1, fs, x, a, sx, sa);
    tick();
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    check("single_early", out_valid, 0);
    tick();
    check("single_valid", out_valid, 1);
    check("single_tap", out_tap, etap);
    check("single_w", $signed(out_w), ew);
    check("single_sat", out_sat, esat);
    tick();
    check("single_once", out_valid, 0);
  endtask

  initial begin
    // ---------------- reset state ----------------
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_tap", out_tap, 0);
    check("rst_out_w", $signed(out_w), 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_rd_data", $signed(rd_data), 0);
    check("rst_t1_ready", t1_in_ready, 0);

    // ---------------- clear sweep after release ----------------
    rst_n = 1'b1;
    for (int i = 1; i <= TAPS; i++) begin
      tick();
      check("boot_in_ready", in_ready, i == TAPS);
      if (i == 1) check("boot_t1_ready", t1_in_ready, 1);
    end
    for (int k = 0; k < TAPS; k++) begin
      rd_addr = TW'(k);
      tick();
      check("boot_rd_zero", $signed(rd_data), 0);
    end

    // ---------------- TAPS = 1: forwarding chain ----------------
    for (int c = 0; c < 7; c++) begin
      t1_in_valid = (c < 4);
      t1_x_in     = WIDTH'(1);
      t1_a_in     = WIDTH'(1);
      tick();
      if (c >= 2 && c < 6) begin
        check("t1_valid", t1_out_valid, 1);
        check("t1_tap", t1_out_tap, 0);
        check("t1_w", $signed(t1_out_w), 2 * (c - 1));
      end else begin
        check("t1_idle", t1_out_valid, 0);
      end
    end
    tick();
    check("t1_rd", $signed(t1_rd_data), 8);

    // ---------------- sub patterns on taps 0..3 ----------------
    for (int c = 0; c < 7; c++) begin
      if (c < 4) drive(1'b1, c == 0, 5, 3, c[0], c[1]);
      else       drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      tick();
      if (c >= 2 && c < 6) begin
        check("b1_valid", out_valid, 1);
        check("b1_tap", out_tap, c - 2);
        check("b1_w", $signed(out_w), exp_b1_w[c-2]);
        check("b1_sat", out_sat, 0);
      end else begin
        check("b1_idle", out_valid, 0);
      end
    end

    // ---------------- saturation ----------------
    single(1'b1, 0,   0,   1'b0, 1'b0, 0, 8,    1'b0);
    single(1'b0, 0,   0,   1'b0, 1'b0, 1, -2,   1'b0);
    single(1'b0, 249, 249, 1'b0, 1'b0, 2, 500,  1'b0);
    single(1'b0, 246, 246, 1'b1, 1'b1, 3, -500, 1'b0);
    single(1'b1, 0,   0,   1'b0, 1'b0, 0, 8,    1'b0);
    single(1'b0, 0,   0,   1'b0, 1'b0, 1, -2,   1'b0);
    single(1'b0, 20,  0,   1'b0, 1'b0, 2, 511,  1'b1);
    single(1'b0, 20,  10,  1'b1, 1'b1, 3, -512, 1'b1);
    rd_addr = TW'(2);
    tick();
    check("sat_rd_max", $signed(rd_data), 511);
    rd_addr = TW'(3);
    tick();
    check("sat_rd_min", $signed(rd_data), -512);

    // ---------------- frame_start mid-stream ----------------
    for (int c = 0; c < 8; c++) begin
      if (c < 5) drive(1'b1, (c == 0) || (c == 2), 1, 1, 1'b0, 1'b0);
      else       drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      tick();
      if (c >= 2 && c < 7) begin
        check("b2_valid", out_valid, 1);
        check("b2_tap", out_tap, exp_b2_tap[c-2]);
        check("b2_w", $signed(out_w), exp_b2_w[c-2]);
        check("b2_sat", out_sat, exp_b2_sat[c-2]);
      end else begin
        check("b2_idle", out_valid, 0);
      end
    end

    // ---------------- clear one cycle after an accept ----------------
    drive(1'b1, 1'b1, 100, 0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    clear = 1'b1;
    #1;
    check("clr_pulse_ready", in_ready, 0);
    tick();
    clear = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      check("clr_ready_low", in_ready, 0);
      check("clr_no_valid", out_valid, 0);
      tick();
    end
    check("clr_ready_high", in_ready, 1);
    for (int k = 0; k < TAPS; k++) begin
      rd_addr = TW'(k);
      tick();
      check("clr_rd_zero", $signed(rd_data), 0);
    end

    // ---------------- asynchronous reset mid-stream ----------------
    rd_addr = TW'(1);
    drive(1'b1, 1'b0, 7, 0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 9, 0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    check("ms_tap0_w", $signed(out_w), 7);
    tick();
    check("ms_valid", out_valid, 1);
    check("ms_tap", out_tap, 1);
    check("ms_w", $signed(out_w), 9);
    check("ms_rd_write_first", $signed(rd_data), 9);
    #2;
    rst_n = 1'b0;
    #1;
    check("ms_rst_ready", in_ready, 0);
    check("ms_rst_valid", out_valid, 0);
    check("ms_rst_tap", out_tap, 0);
    check("ms_rst_w", $signed(out_w), 0);
    check("ms_rst_sat", out_sat, 0);
    check("ms_rst_rd", $signed(rd_data), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 1; i <= TAPS; i++) begin
      tick();
      check("ms_boot_ready", in_ready, i == TAPS);
    end
    tick();
    check("ms_boot_rd", $signed(rd_data), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
